// File: rtl/traffic_cmd_parser.sv
// Framed command byte-stream parser for the traffic light controller.
// Validates header sync/type, assembles big-endian 16-bit data, and emits
// one-cycle command or error pulses. Frames stalled too long are dropped.
module traffic_cmd_parser #(
    parameter int unsigned TIMEOUT_CYC  = 1000,
    parameter logic [2:0]  SYNC_PATTERN = 3'b101
) (
    input  logic        clk_i,
    input  logic        srst_n_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [2:0]  cmd_type_o,
    output logic        cmd_valid_o,
    output logic [15:0] cmd_data_o,
    output logic        err_o,
    output logic [1:0]  err_code_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYC);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYC - 1);

    localparam logic [1:0] ErrSync    = 2'd1;
    localparam logic [1:0] ErrContent = 2'd2;
    localparam logic [1:0] ErrTimeout = 2'd3;

    typedef enum logic [1:0] {StIdle, StGetHi, StGetLo, StIssue} state_e;

    state_e          r_state;
    logic [CntW-1:0] r_tcnt;
    logic [2:0]      r_type;
    logic [7:0]      r_hi;
    logic            r_cmd_valid;
    logic [2:0]      r_cmd_type;
    logic [15:0]     r_cmd_data;
    logic            r_err;
    logic [1:0]      r_err_code;

    logic        w_hs;
    logic        w_sync_ok;
    logic        w_rsv_ok;
    logic [2:0]  w_hdr_type;
    logic [15:0] w_data;
    logic        w_tmo;

    // Ready is gated by reset directly so the link is stalled during reset.
    assign rx_ready_o = srst_n_i & (r_state != StIssue);
    assign w_hs       = rx_valid_i & rx_ready_o;
    assign w_sync_ok  = (rx_data_i[7:5] == SYNC_PATTERN);
    assign w_rsv_ok   = (rx_data_i[4:3] == 2'b00);
    assign w_hdr_type = rx_data_i[2:0];
    assign w_data     = {r_hi, rx_data_i};
    // A byte arriving on the boundary cycle wins over the timeout.
    assign w_tmo      = (r_tcnt == TimeoutLast) & ~w_hs;

    // Frame FSM with registered command/error outputs and stall timer.
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            r_state     <= StIdle;
            r_tcnt      <= '0;
            r_type      <= '0;
            r_hi        <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd_type  <= '0;
            r_cmd_data  <= '0;
            r_err       <= 1'b0;
            r_err_code  <= '0;
        end else begin
            r_cmd_valid <= 1'b0;
            r_err       <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    r_tcnt <= '0;
                    if (w_hs) begin
                        if (!w_sync_ok) begin
                            r_err      <= 1'b1;
                            r_err_code <= ErrSync;
                        end else if (!w_rsv_ok || w_hdr_type > 3'd5) begin
                            r_err      <= 1'b1;
                            r_err_code <= ErrContent;
                        end else if (w_hdr_type <= 3'd2) begin
                            r_cmd_valid <= 1'b1;
                            r_cmd_type  <= w_hdr_type;
                            r_cmd_data  <= '0;
                            r_state     <= StIssue;
                        end else begin
                            r_type  <= w_hdr_type;
                            r_state <= StGetHi;
                        end
                    end
                end
                StGetHi: begin
                    if (w_hs) begin
                        r_hi    <= rx_data_i;
                        r_tcnt  <= '0;
                        r_state <= StGetLo;
                    end else if (w_tmo) begin
                        r_err      <= 1'b1;
                        r_err_code <= ErrTimeout;
                        r_tcnt     <= '0;
                        r_state    <= StIdle;
                    end else begin
                        r_tcnt <= r_tcnt + CntW'(1);
                    end
                end
                StGetLo: begin
                    if (w_hs) begin
                        r_tcnt <= '0;
                        if (w_data == 16'h0000) begin
                            r_err      <= 1'b1;
                            r_err_code <= ErrContent;
                            r_state    <= StIdle;
                        end else begin
                            r_cmd_valid <= 1'b1;
                            r_cmd_type  <= r_type;
                            r_cmd_data  <= w_data;
                            r_state     <= StIssue;
                        end
                    end else if (w_tmo) begin
                        r_err      <= 1'b1;
                        r_err_code <= ErrTimeout;
                        r_tcnt     <= '0;
                        r_state    <= StIdle;
                    end else begin
                        r_tcnt <= r_tcnt + CntW'(1);
                    end
                end
                StIssue: begin
                    r_tcnt  <= '0;
                    r_state <= StIdle;
                end
                default: begin
                    r_tcnt  <= '0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign cmd_valid_o = r_cmd_valid;
    assign cmd_type_o  = r_cmd_type;
    assign cmd_data_o  = r_cmd_data;
    assign err_o       = r_err;
    assign err_code_o  = r_err_code;

endmodule
